// File: rtl/mips_main_ctrl_fsm.sv
// Multicycle MIPS main control FSM with Moore-decoded datapath controls.
// Optional MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall until mem_ready.
module mips_main_ctrl_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       branch,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic [3:0] state,
    output logic       illegal_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t cur, nxt;
    logic   mem_ok;

`ifdef MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic mem_ready_unused;
    assign mem_ready_unused = mem_ready;
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur <= S_FETCH;
        else        cur <= nxt;
    end

    assign state = cur;

    always_comb begin
        nxt        = cur;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        illegal_op = 1'b0;
        case (cur)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ok;
                pcwrite = mem_ok;
                if (mem_ok) nxt = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BEQ;
                    OP_ADDI:      nxt = S_ADDIEX;
                    OP_J:         nxt = S_JUMP;
                    default: begin
                        nxt        = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                // IR is stable, so the opcode can be re-examined here
                if (op == OP_LW)      nxt = S_MEMRD;
                else if (op == OP_SW) nxt = S_MEMWR;
                else                  nxt = S_FETCH;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ok) nxt = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                nxt      = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = mem_ok;
                if (mem_ok) nxt = S_FETCH;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                nxt     = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                nxt      = S_FETCH;
            end
            S_BEQ: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                nxt     = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nxt     = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                nxt      = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                nxt     = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
        // Controls are forced quiet while reset is held
        if (!reset) begin
            pcwrite    = 1'b0;
            branch     = 1'b0;
            iord       = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = 2'b00;
            pcsrc      = 2'b00;
            aluop      = 2'b00;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_main_ctrl_fsm.sv
// Scoreboard bench for mips_main_ctrl_fsm: random opcodes vs. an
// instruction-level model of state paths and per-state controls.
module tb_mips_main_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic       mem_ready = 1'b1;
    logic       pcwrite, branch, iord, memwrite, irwrite;
    logic       regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;
    logic       illegal_op;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef logic [3:0] sq_t[$];
    logic [19:0] expq[$];

    mips_main_ctrl_fsm dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .branch(branch), .iord(iord),
        .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
        .state(state), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    function automatic bit legal(input logic [5:0] o);
        return o inside {6'b000000, 6'b100011, 6'b101011,
                         6'b000100, 6'b001000, 6'b000010};
    endfunction

    // State sequence an instruction walks, FETCH first
    function automatic sq_t path(input logic [5:0] o);
        sq_t p;
        case (o)
            6'b100011: p = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
            6'b101011: p = '{4'd0, 4'd1, 4'd2, 4'd5};
            6'b000000: p = '{4'd0, 4'd1, 4'd6, 4'd7};
            6'b001000: p = '{4'd0, 4'd1, 4'd9, 4'd10};
            6'b000100: p = '{4'd0, 4'd1, 4'd8};
            6'b000010: p = '{4'd0, 4'd1, 4'd11};
            default:   p = '{4'd0, 4'd1};
        endcase
        return p;
    endfunction

    // {state,pcw,br,iord,mw,irw,rdst,m2r,rw,asa,asb,pcs,aop,ill}
    function automatic logic [19:0] model(input logic [3:0] st,
                                          input logic [5:0] o);
        logic pcw, br, io, mw, irw, rd, m2r, rw, asa, ill;
        logic [1:0] asb, pcs, aop;
        {pcw, br, io, mw, irw, rd, m2r, rw, asa, ill} = '0;
        asb = 2'b00; pcs = 2'b00; aop = 2'b00;
        case (st)
            4'd0:  begin asb = 2'b01; irw = 1; pcw = 1; end
            4'd1:  begin asb = 2'b11; ill = !legal(o); end
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  io = 1;
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin io = 1; mw = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
            4'd9:  begin asa = 1; asb = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {st, pcw, br, io, mw, irw, rd, m2r, rw, asa,
                asb, pcs, aop, ill};
    endfunction

    // Monitor: one comparison per cycle, mid-cycle
    always @(negedge clk) begin
        logic [19:0] act, exp_v;
        cyc++;
        if (expq.size() > 0) begin
            exp_v = expq.pop_front();
            act = {state, pcwrite, branch, iord, memwrite, irwrite,
                   regdst, memtoreg, regwrite, alusrca,
                   alusrcb, pcsrc, aluop, illegal_op};
            checks++;
            if (act !== exp_v) begin
                fails++;
                $display("FAIL ctl cyc=%0d op=%b got=%h exp=%h",
                         cyc, op, act, exp_v);
            end
        end
    end

    // Called at posedge+1 of the instruction's FETCH cycle
    task automatic run_instr(input logic [5:0] o);
        sq_t p;
        p = path(o);
        op = o;
        foreach (p[j]) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            expq.push_back(model(p[j], o));
        end
        @(posedge clk); #1;
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            expq.push_back(20'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] o;
        sq_t p;
        int n;
        ops = '{6'b100011, 6'b101011, 6'b000000,
                6'b000100, 6'b000010, 6'b001000};
        #2 reset = 1'b0;
        hold_reset(2);
        run_instr(6'b100011);
        run_instr(6'b101011);
        run_instr(6'b000000);
        run_instr(6'b000100);
        run_instr(6'b000010);
        run_instr(6'b001000);
        run_instr(6'b111111);
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) o = 6'($urandom_range(0, 63));
            else o = ops[$urandom_range(0, 5)];
            run_instr(o);
        end
        // lw aborted by reset once it has reached MEMRD
        op = 6'b100011;
        p = path(op);
        for (int j = 0; j < 3; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            expq.push_back(model(p[j], op));
        end
        @(posedge clk); #1;
        reset = 1'b0;
        expq.push_back(20'd0);
        hold_reset(1);
        run_instr(6'b101011);
        run_instr(6'b011111);
        n = 0;
        while (expq.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        if (expq.size() > 0) begin
            fails++;
            $display("FAIL drain left=%0d exp=0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
